// File: rtl/led_rate_sequencer_pkg.sv
// Shared definitions for the walking-LED rate sequencer: controller states,
// default build parameters and the fixed LED patterns used by the datapath.
package led_rate_sequencer_pkg;

    // Default prescaler width, rate-0 tap exponent and lap count.
    localparam int DEF_DIV_W    = 27;
    localparam int DEF_BASE_TAP = 20;
    localparam int DEF_LAPS     = 4;

    // LED patterns: dark, first position of a lap, last position of a lap.
    localparam logic [7:0] LED_OFF   = 8'h00;
    localparam logic [7:0] LED_FIRST = 8'h01;
    localparam logic [7:0] LED_LAST  = 8'h80;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/led_rate_sequencer_tick_gen.sv
// Prescaler and tap compare for the LED sequencer. The counter is cleared,
// advanced or held under control of the sequencer FSM; tick marks the cycle
// in which the low TAP bits of the counter are all ones.
module led_rate_sequencer_tick_gen
    import led_rate_sequencer_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int BASE_TAP = DEF_BASE_TAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,    // advance the prescaler this cycle
    input  logic       clear,  // force the prescaler to zero (wins over run)
    input  logic [1:0] rate,   // latched rate select; TAP = BASE_TAP + 2*rate
    output logic       tick
);

    // Low-bit masks for the four tap choices. DIV_W must be at least
    // BASE_TAP+6 so that the slowest tap still fits inside the counter.
    localparam logic [DIV_W-1:0] ONES  = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] MASK0 = ONES >> (DIV_W - BASE_TAP);
    localparam logic [DIV_W-1:0] MASK1 = ONES >> (DIV_W - BASE_TAP - 2);
    localparam logic [DIV_W-1:0] MASK2 = ONES >> (DIV_W - BASE_TAP - 4);
    localparam logic [DIV_W-1:0] MASK3 = ONES >> (DIV_W - BASE_TAP - 6);

    logic [DIV_W-1:0] prescaler;
    logic [DIV_W-1:0] tap_mask;

    // Prescaler: clear has priority, otherwise count while running, else hold.
    // NOTE: clocked state is always updated with <= so every flop samples the
    // pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (clear) begin
            prescaler <= '0;
        end else if (run) begin
            prescaler <= prescaler + DIV_W'(1);
        end
    end

    // Select the mask of prescaler bits that must all be ones for a tick.
    // NOTE: the default assignment ahead of the case keeps this block purely
    // combinational; a path that left tap_mask unassigned would infer a latch.
    always_comb begin
        tap_mask = MASK0;
        case (rate)
            2'd0: tap_mask = MASK0;
            2'd1: tap_mask = MASK1;
            2'd2: tap_mask = MASK2;
            2'd3: tap_mask = MASK3;
            default: tap_mask = MASK0;
        endcase
    end

    // A tick only exists while the prescaler is actually running, so a frozen
    // all-ones count in PAUSE stays pending until RUN resumes.
    assign tick = run && ((prescaler & tap_mask) == tap_mask);

endmodule

// File: rtl/led_rate_sequencer.sv
// Walking-one LED sequencer. start/stop rising edges move a three-state
// controller (IDLE/RUN/PAUSE); in RUN a prescaler tick rotates the LED
// pattern, each 80->01 wrap counts a lap and picks up a new rate, and after
// LAPS laps (LAPS=0: never) the sequencer returns to IDLE by itself.
module led_rate_sequencer
    import led_rate_sequencer_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int BASE_TAP = DEF_BASE_TAP,
    parameter int LAPS     = DEF_LAPS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] rate_sel,
    output logic [7:0] led,
    output logic       busy,
    output logic       tick
);

    // Lap counter only needs to reach LAPS-1 before the final wrap; with
    // LAPS=0 it simply rolls over and is never compared.
    localparam int LAP_W = (LAPS < 2) ? 1 : $clog2(LAPS + 1);
    localparam logic [LAP_W-1:0] LAP_FINAL = (LAPS == 0) ? '0 : LAP_W'(LAPS - 1);

    state_t           state;
    state_t           next_state;
    logic             start_q;
    logic             stop_q;
    logic             start_rise;
    logic             stop_rise;
    logic [LAP_W-1:0] lap_cnt;
    logic [1:0]       rate_q;
    logic             wrap;
    logic             final_lap;
    logic             presc_run;
    logic             presc_clear;
    logic             load;

    // Previous-cycle samples of start/stop. They reset high so a level that
    // is already high when reset releases is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b1;
            stop_q  <= 1'b1;
        end else begin
            start_q <= start;
            stop_q  <= stop;
        end
    end

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop & ~stop_q;

    // The current step is the last position of a lap; final_lap says that
    // completing this lap reaches the configured lap count.
    assign wrap      = (led == LED_LAST);
    assign final_lap = (LAPS != 0) && (lap_cnt == LAP_FINAL);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a stop edge always wins over a simultaneous start edge.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_rise && !stop_rise) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_rise) begin
                    next_state = ST_PAUSE;
                end else if (tick && wrap && final_lap) begin
                    next_state = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (stop_rise) begin
                    next_state = ST_IDLE;
                end else if (start_rise) begin
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Moore-style outputs and datapath controls decoded from the current state.
    // The prescaler does not advance on a stop edge so PAUSE freezes the count
    // exactly where RUN left it, including a pending all-ones tick.
    always_comb begin
        busy      = 1'b0;
        presc_run = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                load = start_rise && !stop_rise;
            end
            ST_RUN: begin
                busy      = 1'b1;
                presc_run = !stop_rise;
            end
            ST_PAUSE: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Keep the prescaler at zero throughout IDLE, including the edge that
    // enters it, so every new run starts from a full period.
    assign presc_clear = (state == ST_IDLE) || (next_state == ST_IDLE);

    // LED pattern, lap count and latched rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            led     <= LED_OFF;
            lap_cnt <= '0;
            rate_q  <= 2'b00;
        end else if (next_state == ST_IDLE) begin
            led     <= LED_OFF;
            lap_cnt <= '0;
        end else if (load) begin
            led     <= LED_FIRST;
            lap_cnt <= '0;
            rate_q  <= rate_sel;
        end else if (tick) begin
            if (wrap) begin
                led     <= LED_FIRST;
                lap_cnt <= lap_cnt + LAP_W'(1);
                rate_q  <= rate_sel;
            end else begin
                led <= {led[6:0], led[7]};
            end
        end
    end

    // Prescaler and tap compare.
    led_rate_sequencer_tick_gen #(
        .DIV_W    (DIV_W),
        .BASE_TAP (BASE_TAP)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (presc_run),
        .clear (presc_clear),
        .rate  (rate_q),
        .tick  (tick)
    );

endmodule

// File: tb/tb_led_rate_sequencer.sv
// Self-checking bench for led_rate_sequencer (BASE_TAP=2, LAPS=2, DIV_W=10).
// Every cycle is compared against a behavioural model; directed tables and
// sequences add explicit expectations for the corner cases.
module tb_led_rate_sequencer;

    localparam int DIV_W    = 10;
    localparam int BASE_TAP = 2;
    localparam int LAPS     = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] rate_sel;
    logic [7:0] led;
    logic       busy;
    logic       tick;

    led_rate_sequencer #(
        .DIV_W    (DIV_W),
        .BASE_TAP (BASE_TAP),
        .LAPS     (LAPS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .rate_sel (rate_sel),
        .led      (led),
        .busy     (busy),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    string phase       = "init";

    // Behavioural model: mode, lit LED position (-1 = dark), laps done,
    // cycles counted since the run started, and the rate in force.
    int   m_mode;
    int   m_pos;
    int   m_laps;
    int   m_cnt;
    int   m_rate;
    bit   m_start_q;
    bit   m_stop_q;
    bit   m_srise;
    bit   m_prise;
    bit   m_tick;
    bit   m_busy;
    logic [7:0] m_led;

    logic [7:0] obs_led;
    logic       obs_busy;
    logic       obs_tick;

    typedef struct {
        bit         start;
        bit         stop;
        logic [1:0] rate;
        logic [7:0] led;
        bit         busy;
        bit         tick;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h (t=%0t)", phase, name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_pos     = -1;
        m_laps    = 0;
        m_cnt     = 0;
        m_rate    = 0;
        m_start_q = 1'b1;
        m_stop_q  = 1'b1;
    endtask

    task automatic model_go_idle();
        m_mode = M_IDLE;
        m_pos  = -1;
        m_cnt  = 0;
        m_laps = 0;
    endtask

    // Expected outputs for the current cycle given the applied inputs.
    task automatic model_eval();
        int period;
        period  = 1 << (BASE_TAP + 2 * m_rate);
        m_srise = start && !m_start_q;
        m_prise = stop && !m_stop_q;
        m_led   = (m_pos < 0) ? 8'h00 : 8'(1 << m_pos);
        m_busy  = (m_mode != M_IDLE);
        m_tick  = (m_mode == M_RUN) && !m_prise && ((m_cnt % period) == period - 1);
    endtask

    // Advance the model across one clock edge.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            m_start_q = start;
            m_stop_q  = stop;
            case (m_mode)
                M_IDLE: begin
                    if (!m_prise && m_srise) begin
                        m_mode = M_RUN;
                        m_pos  = 0;
                        m_cnt  = 0;
                        m_laps = 0;
                        m_rate = int'(rate_sel);
                    end
                end
                M_RUN: begin
                    if (m_prise) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_cnt = (m_cnt + 1) % (1 << DIV_W);
                        if (m_tick) begin
                            if (m_pos == 7) begin
                                m_laps++;
                                if (LAPS != 0 && m_laps == LAPS) begin
                                    model_go_idle();
                                end else begin
                                    m_pos  = 0;
                                    m_rate = int'(rate_sel);
                                end
                            end else begin
                                m_pos++;
                            end
                        end
                    end
                end
                default: begin
                    if (m_prise) begin
                        model_go_idle();
                    end else if (m_srise) begin
                        m_mode = M_RUN;
                    end
                end
            endcase
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, step the
    // model at the rising edge, return 1 time unit after it.
    task automatic cycle(input bit r, input bit s, input bit p, input logic [1:0] rs);
        rst      = r;
        start    = s;
        stop     = p;
        rate_sel = rs;
        @(negedge clk);
        model_eval();
        obs_led  = led;
        obs_busy = busy;
        obs_tick = tick;
        check("led", 32'(led), 32'(m_led));
        check("busy", 32'(busy), 32'(m_busy));
        check("tick", 32'(tick), 32'(m_tick));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic [1:0] rs);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, rs);
        end
    endtask

    // Two stop pulses take RUN -> PAUSE -> IDLE (or PAUSE -> IDLE -> IDLE).
    task automatic abort_run();
        cycle(1'b0, 1'b0, 1'b1, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 1'b1, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);
        check("abort_busy", 32'(busy), 32'd0);
    endtask

    // Run cycles until a tick is observed; returns its cycle index or -1.
    task automatic wait_tick(input int limit, input logic [1:0] rs, output int n_out);
        n_out = -1;
        for (int n = 1; n <= limit; n++) begin
            cycle(1'b0, 1'b0, 1'b0, rs);
            if (obs_tick === 1'b1) begin
                n_out = n;
                break;
            end
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int ticks[$];

        tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 8'h01, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h01, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 8'h01, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'h01, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 8'h02, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'h02, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 8'h02, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 8'h02, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'h04, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 8'h04, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 8'h04, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h04, 1'b1, 1'b1};

        // Reset with start held high; no edge may be seen after release.
        phase    = "reset_start_high";
        rst      = 1'b1;
        start    = 1'b1;
        stop     = 1'b0;
        rate_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle(1'b1, 1'b1, 1'b0, 2'd0);
        cycle(1'b1, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'd0);
        end
        check("led", 32'(led), 32'h00);
        check("busy", 32'(busy), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);

        // Rate 0 full run: table covers the first steps, then auto-return.
        phase = "table_rate0";
        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, tbl[i].start, tbl[i].stop, tbl[i].rate);
            check($sformatf("row%0d_led", i), 32'(obs_led), 32'(tbl[i].led));
            check($sformatf("row%0d_busy", i), 32'(obs_busy), 32'(tbl[i].busy));
            check($sformatf("row%0d_tick", i), 32'(obs_tick), 32'(tbl[i].tick));
        end
        phase = "auto_return";
        idle_cycles(51, 2'd0);
        check("led_at_63", 32'(led), 32'h80);
        check("busy_at_63", 32'(busy), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);
        check("led_at_64", 32'(led), 32'h00);
        check("busy_at_64", 32'(busy), 32'd0);

        // Slowest rate: first tick 256 cycles after the entry edge.
        phase = "rate3_first_tick";
        cycle(1'b0, 1'b0, 1'b0, 2'd3);
        cycle(1'b0, 1'b1, 1'b0, 2'd3);
        wait_tick(300, 2'd3, first);
        check("first_tick_cycle", 32'(first), 32'd256);
        abort_run();

        // Pause at 08 for 50 cycles, resume finishes the partial period.
        phase = "pause_resume";
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        idle_cycles(13, 2'd0);
        check("led_before_pause", 32'(led), 32'h08);
        cycle(1'b0, 1'b0, 1'b1, 2'd0);
        idle_cycles(50, 2'd0);
        check("led_paused", 32'(led), 32'h08);
        check("busy_paused", 32'(busy), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        wait_tick(10, 2'd0, first);
        check("resume_tick_cycle", 32'(first), 32'd3);
        abort_run();

        // Simultaneous start/stop edges in RUN pause; in IDLE do nothing.
        phase = "start_stop_together";
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        idle_cycles(2, 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 2'd0);
        idle_cycles(10, 2'd0);
        check("led_held", 32'(led), 32'h01);
        check("busy_held", 32'(busy), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 2'd0);
        check("busy_after_stop", 32'(busy), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);
        check("idle_both_busy", 32'(busy), 32'd0);
        check("idle_both_led", 32'(led), 32'h00);

        // Stop edge on a tick cycle: no step, tick deferred to resume.
        phase = "stop_on_tick";
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        idle_cycles(3, 2'd0);
        cycle(1'b0, 1'b0, 1'b1, 2'd0);
        check("tick_suppressed", 32'(obs_tick), 32'd0);
        check("led_not_advanced", 32'(led), 32'h01);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);
        check("tick_on_resume", 32'(obs_tick), 32'd1);
        check("led_after_resume", 32'(led), 32'h02);
        abort_run();

        // Reset in the middle of a run.
        phase = "reset_mid_run";
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        idle_cycles(5, 2'd0);
        cycle(1'b1, 1'b0, 1'b0, 2'd0);
        check("led", 32'(led), 32'h00);
        check("busy", 32'(busy), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0);

        // Rate change mid-lap takes effect only at the wrap.
        phase = "rate_change";
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        for (int n = 1; n <= 400; n++) begin
            cycle(1'b0, 1'b0, 1'b0, (n >= 10) ? 2'd1 : 2'd0);
            if (obs_tick === 1'b1) begin
                ticks.push_back(n);
            end
            if (ticks.size() >= 9) begin
                break;
            end
        end
        check("tick_count", 32'(ticks.size()), 32'd9);
        if (ticks.size() >= 9) begin
            check("wrap_tick_cycle", 32'(ticks[7]), 32'd32);
            check("period_before_wrap", 32'(ticks[7] - ticks[6]), 32'd4);
            check("period_after_wrap", 32'(ticks[8] - ticks[7]), 32'd16);
        end
        abort_run();

        // Randomized traffic against the model.
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            cycle(bit'($urandom_range(0, 399) == 0),
                  bit'($urandom_range(0, 5) == 0),
                  bit'($urandom_range(0, 39) == 0),
                  2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
